// File: rtl/clk_region_pkg.sv
// Shared constants and FSM state type for the pixel-region column divider.
package clk_region_pkg;

  localparam int unsigned L_MIN    = 220;
  localparam int unsigned R_MAX    = 1060;
  localparam int unsigned T_MIN    = 210;
  localparam int unsigned B_MAX    = 510;
  localparam int unsigned FRAC_DEF = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_PEND
  } state_t;

endpackage

// File: rtl/clk_region_split_calc.sv
// Sequential split-point calculator: one clamped weight * span product per step,
// results held in staging registers until the top commits them.
module clk_region_split_calc
  import clk_region_pkg::*;
#(
  parameter int unsigned N_REG = 3,
  parameter int unsigned XW    = 11,
  parameter int unsigned FRAC  = FRAC_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       load,
  input  logic                       step,
  input  logic [XW-1:0]              left,
  input  logic [XW-1:0]              right,
  input  logic [(N_REG-1)*FRAC-1:0]  split_w,
  output logic                       last,
  output logic [(N_REG+1)*XW-1:0]    stage_bound
);

  localparam int unsigned KW = $clog2(N_REG);

  logic [XW-1:0]             left_q;
  logic [XW-1:0]             right_q;
  logic [XW-1:0]             span;
  logic [XW-1:0]             s_k;
  logic [(N_REG-1)*FRAC-1:0] w_q;
  logic [(N_REG-1)*FRAC-1:0] w_shift;
  logic [FRAC-1:0]           w_cur;
  logic [FRAC-1:0]           w_prev;
  logic [FRAC-1:0]           w_clamp;
  logic [KW-1:0]             k_q;
  logic [XW+FRAC-1:0]        prod;

  assign span    = right_q - left_q;
  assign w_shift = w_q >> (int'(k_q) * FRAC);
  assign w_cur   = w_shift[FRAC-1:0];
  // Running maximum keeps split points monotonic even for unordered weights.
  assign w_clamp = (w_cur > w_prev) ? w_cur : w_prev;
  assign prod    = {{FRAC{1'b0}}, span} * {{XW{1'b0}}, w_clamp};
  assign s_k     = left_q + prod[XW+FRAC-1:FRAC];
  assign last    = (k_q == KW'(N_REG - 2));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      left_q      <= '0;
      right_q     <= '0;
      w_q         <= '0;
      w_prev      <= '0;
      k_q         <= '0;
      stage_bound <= '0;
    end else if (load) begin
      left_q                          <= left;
      right_q                         <= right;
      w_q                             <= split_w;
      w_prev                          <= '0;
      k_q                             <= '0;
      stage_bound[0 +: XW]            <= left;
      stage_bound[N_REG*XW +: XW]     <= right;
    end else if (step) begin
      stage_bound[(int'(k_q) + 1)*XW +: XW] <= s_k;
      w_prev                                <= w_clamp;
      k_q                                   <= k_q + KW'(1);
    end
  end

endmodule

// File: rtl/clk_region_divider_n.sv
// N-column screen-region divider: config FSM with frame-synchronous commit and a
// registered one-hot per-region enable for every pixel.
module clk_region_divider_n
  import clk_region_pkg::*;
#(
  parameter int unsigned N_REG = 3,
  parameter int unsigned XW    = 11,
  parameter int unsigned YW    = 10,
  parameter int unsigned FRAC  = FRAC_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        frame_start,
  input  logic                        cfg_valid,
  input  logic [XW-1:0]               left,
  input  logic [XW-1:0]               right,
  input  logic [YW-1:0]               top,
  input  logic [YW-1:0]               bottom,
  input  logic [(N_REG-1)*FRAC-1:0]   split_w,
  input  logic                        pix_valid,
  input  logic [XW-1:0]               x,
  input  logic [YW-1:0]               y,
  output logic [N_REG-1:0]            en,
  output logic [$clog2(N_REG)-1:0]    region_idx,
  output logic                        out_valid,
  output logic                        outside,
  output logic                        busy,
  output logic                        cfg_err,
  output logic [(N_REG+1)*XW-1:0]     bound
);

  localparam int unsigned IW = $clog2(N_REG);
  localparam logic [XW-1:0] WIN_L = XW'(L_MIN);
  localparam logic [XW-1:0] WIN_R = XW'(R_MAX);
  localparam logic [YW-1:0] WIN_T = YW'(T_MIN);
  localparam logic [YW-1:0] WIN_B = YW'(B_MAX);

  state_t state, state_nx;
  logic   load, step, commit, reject, last, cfg_bad;
  logic   cfg_ok;
  logic [(N_REG+1)*XW-1:0] stage_bound;
  logic [YW-1:0]           stage_top, stage_bot;
  logic [YW-1:0]           top_r, bot_r;
  logic [N_REG-1:0]        hit;
  logic                    in_win, in_rows;
  logic [N_REG-1:0]        en_nx;
  logic [IW-1:0]           idx_nx;
  logic                    outside_nx;

  assign cfg_bad = (right <= left) || (bottom <= top);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    step     = 1'b0;
    commit   = 1'b0;
    reject   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (cfg_bad) begin
            reject = 1'b1;
          end else begin
            load     = 1'b1;
            state_nx = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        step = 1'b1;
        if (last) state_nx = ST_PEND;
      end
      ST_PEND: begin
        if (frame_start) begin
          commit   = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  clk_region_split_calc #(
    .N_REG (N_REG),
    .XW    (XW),
    .FRAC  (FRAC)
  ) u_split_calc (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (load),
    .step        (step),
    .left        (left),
    .right       (right),
    .split_w     (split_w),
    .last        (last),
    .stage_bound (stage_bound)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_top <= '0;
      stage_bot <= '0;
      top_r     <= '0;
      bot_r     <= '0;
      bound     <= '0;
      cfg_ok    <= 1'b0;
      busy      <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      busy    <= (state_nx != ST_IDLE);
      cfg_err <= reject;
      if (load) begin
        stage_top <= top;
        stage_bot <= bottom;
      end
      if (commit) begin
        bound  <= stage_bound;
        top_r  <= stage_top;
        bot_r  <= stage_bot;
        cfg_ok <= 1'b1;
      end
    end
  end

  for (genvar k = 0; k < N_REG; k++) begin : g_col
    logic [XW-1:0] lo, hi;
    assign lo     = bound[k*XW +: XW];
    assign hi     = bound[(k+1)*XW +: XW];
    assign hit[k] = (x >= lo) && (x < hi);
  end

  assign in_win  = (x >= WIN_L) && (x <= WIN_R) && (y >= WIN_T) && (y <= WIN_B);
  assign in_rows = cfg_ok && (y >= top_r) && (y < bot_r);

  // Descending scan so the lowest-indexed hitting column is the one that sticks.
  always_comb begin
    en_nx      = '0;
    idx_nx     = '0;
    outside_nx = 1'b0;
    if (pix_valid) begin
      if (!in_win) begin
        en_nx      = '1;
        outside_nx = 1'b1;
      end else if (in_rows) begin
        for (int unsigned i = N_REG; i > 0; i--) begin
          if (hit[i-1]) begin
            en_nx  = N_REG'(1) << (i - 1);
            idx_nx = IW'(i - 1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en         <= '0;
      region_idx <= '0;
      out_valid  <= 1'b0;
      outside    <= 1'b0;
    end else begin
      en         <= en_nx;
      region_idx <= idx_nx;
      out_valid  <= pix_valid;
      outside    <= outside_nx;
    end
  end

endmodule

// File: tb/tb_clk_region_divider_n.sv
// Bench for clk_region_divider_n: directed cases plus randomized traffic against
// an arithmetic reference model of boundaries, commit timing and classification.
module tb_clk_region_divider_n;

  localparam int N    = 3;
  localparam int XW   = 11;
  localparam int YW   = 10;
  localparam int FRAC = 6;
  localparam int IW   = $clog2(N);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0, cfg_valid = 1'b0, pix_valid = 1'b0;
  logic [XW-1:0] left = '0, right = '0, x = '0;
  logic [YW-1:0] top = '0, bottom = '0, y = '0;
  logic [(N-1)*FRAC-1:0] split_w = '0;
  logic [N-1:0] en;
  logic [IW-1:0] region_idx;
  logic out_valid, outside, busy, cfg_err;
  logic [(N+1)*XW-1:0] bound;

  clk_region_divider_n #(
    .N_REG (N),
    .XW    (XW),
    .YW    (YW),
    .FRAC  (FRAC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .cfg_valid   (cfg_valid),
    .left        (left),
    .right       (right),
    .top         (top),
    .bottom      (bottom),
    .split_w     (split_w),
    .pix_valid   (pix_valid),
    .x           (x),
    .y           (y),
    .en          (en),
    .region_idx  (region_idx),
    .out_valid   (out_valid),
    .outside     (outside),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .bound       (bound)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nbad = 0;
  bit chk_on = 1'b0;

  // Reference model: active config, pending config, and cycle of acceptance.
  int  m_b[N+1];
  int  p_b[N+1];
  int  m_top, m_bot, p_top, p_bot;
  bit  m_ok, m_pend;
  int  acc_cyc, cyc;

  logic [N-1:0]        e_en;
  logic [IW-1:0]       e_idx;
  logic                e_ov, e_out, e_busy, e_err;
  logic [(N+1)*XW-1:0] e_bound;

  task automatic model_reset();
    for (int k = 0; k <= N; k++) begin
      m_b[k] = 0;
      p_b[k] = 0;
    end
    m_top = 0; m_bot = 0; p_top = 0; p_bot = 0;
    m_ok = 1'b0; m_pend = 1'b0; acc_cyc = 0;
    e_en = '0; e_idx = '0; e_ov = 1'b0; e_out = 1'b0;
    e_busy = 1'b0; e_err = 1'b0; e_bound = '0;
  endtask

  // Predicts the outputs that appear after the coming clock edge.
  task automatic model_eval();
    int xi, yi, wmax, w;
    bit found;
    xi = int'(x);
    yi = int'(y);
    e_ov = pix_valid; e_en = '0; e_idx = '0; e_out = 1'b0; e_err = 1'b0;
    if (pix_valid) begin
      if (xi < 220 || xi > 1060 || yi < 210 || yi > 510) begin
        e_en = '1;
        e_out = 1'b1;
      end else if (m_ok && yi >= m_top && yi < m_bot) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (!found && xi >= m_b[k] && xi < m_b[k+1]) begin
            found = 1'b1;
            e_en = '0;
            e_en[k] = 1'b1;
            e_idx = IW'(k);
          end
        end
      end
    end
    if (m_pend) begin
      if (frame_start && cyc >= acc_cyc + N) begin
        for (int k = 0; k <= N; k++) m_b[k] = p_b[k];
        m_top = p_top; m_bot = p_bot; m_ok = 1'b1; m_pend = 1'b0;
      end
    end else if (cfg_valid) begin
      if (int'(right) <= int'(left) || int'(bottom) <= int'(top)) begin
        e_err = 1'b1;
      end else begin
        wmax = 0;
        p_b[0] = int'(left);
        for (int k = 0; k < N-1; k++) begin
          w = int'(split_w[k*FRAC +: FRAC]);
          if (w > wmax) wmax = w;
          p_b[k+1] = int'(left) + ((int'(right) - int'(left)) * wmax) / 64;
        end
        p_b[N] = int'(right);
        p_top = int'(top); p_bot = int'(bottom);
        m_pend = 1'b1;
        acc_cyc = cyc;
      end
    end
    e_busy = m_pend;
    for (int k = 0; k <= N; k++) e_bound[k*XW +: XW] = XW'(m_b[k]);
    cyc++;
  endtask

  always @(posedge clk) begin
    if (chk_on) begin
      #1;
      nvec++;
      if ({en, region_idx, out_valid, outside, busy, cfg_err, bound} !==
          {e_en, e_idx, e_ov, e_out, e_busy, e_err, e_bound}) begin
        nbad++;
        $display("FAIL cycle_compare t=%0t got en=%b idx=%0d ov=%b out=%b busy=%b err=%b bound=%h want en=%b idx=%0d ov=%b out=%b busy=%b err=%b bound=%h",
                 $time, en, region_idx, out_valid, outside, busy, cfg_err, bound,
                 e_en, e_idx, e_ov, e_out, e_busy, e_err, e_bound);
      end
    end
  end

  task automatic tick();
    model_eval();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    nvec++;
    if (got !== want) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic pix(input int xx, input int yy, input logic [N-1:0] we,
                     input int wi, input logic wo);
    pix_valid = 1'b1;
    x = XW'(xx);
    y = YW'(yy);
    tick();
    check($sformatf("en(%0d,%0d)", xx, yy), 64'(en), 64'(we));
    check($sformatf("idx(%0d,%0d)", xx, yy), 64'(region_idx), 64'(wi));
    check($sformatf("outside(%0d,%0d)", xx, yy), 64'(outside), 64'(wo));
  endtask

  task automatic load_cfg(input int l, input int r, input int t, input int b,
                          input int w1, input int w0);
    cfg_valid = 1'b1;
    left = XW'(l); right = XW'(r); top = YW'(t); bottom = YW'(b);
    split_w = {FRAC'(w1), FRAC'(w0)};
  endtask

  initial begin
    model_reset();
    cyc = 0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_en", 64'(en), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_bound", 64'(bound), 64'd0);
    check("rst_ov_out_err", 64'({out_valid, outside, cfg_err, region_idx}), 64'd0);
    rst_n = 1'b1;
    chk_on = 1'b1;

    // First configuration, committed on the frame strobe after the CALC cycles.
    load_cfg(220, 1060, 250, 450, 45, 19);
    tick();
    cfg_valid = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
    tick();
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("bound_cfg1", 64'(bound), 64'({11'd1060, 11'd810, 11'd469, 11'd220}));
    check("busy_after_commit", 64'(busy), 64'd0);

    pix(300, 300, 3'b001, 0, 1'b0);
    pix(600, 300, 3'b010, 1, 1'b0);
    pix(900, 300, 3'b100, 2, 1'b0);
    pix(469, 300, 3'b010, 1, 1'b0);
    pix(468, 300, 3'b001, 0, 1'b0);
    pix(300, 450, 3'b000, 0, 1'b0);
    pix(100, 300, 3'b111, 0, 1'b1);
    pix(1060, 300, 3'b000, 0, 1'b0);
    pix_valid = 1'b0;

    // Rejected configuration.
    load_cfg(300, 200, 250, 450, 45, 19);
    tick();
    cfg_valid = 1'b0;
    check("cfg_err_pulse", 64'(cfg_err), 64'd1);
    check("busy_on_reject", 64'(busy), 64'd0);
    tick();
    check("cfg_err_clears", 64'(cfg_err), 64'd0);
    check("bound_kept", 64'(bound), 64'({11'd1060, 11'd810, 11'd469, 11'd220}));

    // Non-monotonic weights; frame strobes during accept/CALC and cfg while busy are ignored.
    load_cfg(220, 1060, 250, 450, 10, 30);
    frame_start = 1'b1;
    tick();
    load_cfg(0, 5, 0, 5, 1, 1);
    tick();
    cfg_valid = 1'b0;
    frame_start = 1'b0;
    tick();
    check("busy_pending", 64'(busy), 64'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("bound_clamped", 64'(bound), 64'({11'd1060, 11'd613, 11'd613, 11'd220}));
    pix(613, 300, 3'b100, 2, 1'b0);
    pix(612, 300, 3'b001, 0, 1'b0);
    pix(1059, 300, 3'b100, 2, 1'b0);
    pix_valid = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cfg_valid = ($urandom_range(0, 9) == 0);
      if (cfg_valid) begin
        left = XW'($urandom_range(150, 900));
        right = XW'(int'(left) + int'($urandom_range(0, 600)));
        if ($urandom_range(0, 7) == 0) right = XW'($urandom_range(0, 300));
        top = YW'($urandom_range(180, 450));
        bottom = YW'(int'(top) + int'($urandom_range(0, 200)));
        split_w = (N-1)*FRAC'($urandom);
      end
      frame_start = ($urandom_range(0, 5) == 0);
      pix_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) x = XW'(m_b[$urandom_range(0, N)]);
      else x = XW'($urandom_range(150, 1150));
      y = YW'($urandom_range(180, 560));
      tick();
    end
    cfg_valid = 1'b0;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    repeat (6) tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;

    // Reset in the middle of CALC.
    load_cfg(220, 1060, 250, 450, 45, 19);
    tick();
    cfg_valid = 1'b0;
    tick();
    chk_on = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midcalc_rst_en", 64'(en), 64'd0);
    check("midcalc_rst_busy", 64'(busy), 64'd0);
    check("midcalc_rst_bound", 64'(bound), 64'd0);
    check("midcalc_rst_flags", 64'({out_valid, outside, cfg_err, region_idx}), 64'd0);
    model_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    chk_on = 1'b1;
    pix(300, 300, 3'b000, 0, 1'b0);
    check("post_rst_ov", 64'(out_valid), 64'd1);
    pix_valid = 1'b0;
    tick();
    chk_on = 1'b0;
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
